wb2axi4lite_bridge: RTL and testbench



---
 rtl/wb2axi4lite_bridge.sv | 199 +++++++++++++++++++
 tb/tb_wb2axi4lite_bridge.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb2axi4lite_bridge.sv
// rtl/wb2axi4lite_bridge.sv - Wishbone classic slave to AXI4-Lite master bridge with response timeout
module wb2axi4lite_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DRAIN} state_t;

  state_t                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
  logic [SW-1:0]         r_wstrb, w_wstrb_n;
  logic                  r_we, w_we_n;
  logic                  r_awvalid, w_awvalid_n;
  logic                  r_wvalid, w_wvalid_n;
  logic                  r_bready, w_bready_n;
  logic                  r_arvalid, w_arvalid_n;
  logic                  r_rready, w_rready_n;
  logic                  r_ack, w_ack_n;
  logic                  r_err, w_err_n;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_n;
  logic [CW-1:0]         r_cnt, w_cnt_n;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_aw_done, w_w_done, w_ar_done, w_resp_hs, w_resp_err;
  logic w_unused;

  assign w_aw_hs    = r_awvalid & m_axi_awready;
  assign w_w_hs     = r_wvalid & m_axi_wready;
  assign w_ar_hs    = r_arvalid & m_axi_arready;
  assign w_b_hs     = r_bready & m_axi_bvalid;
  assign w_r_hs     = r_rready & m_axi_rvalid;
  // a channel is "done" once its valid is low after this edge
  assign w_aw_done  = ~r_awvalid | w_aw_hs;
  assign w_w_done   = ~r_wvalid | w_w_hs;
  assign w_ar_done  = ~r_arvalid | w_ar_hs;
  assign w_resp_hs  = w_b_hs | w_r_hs;
  // only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR
  assign w_resp_err = w_b_hs ? m_axi_bresp[1] : m_axi_rresp[1];
  assign w_unused   = ^{m_axi_bresp[0], m_axi_rresp[0]};

  // state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_we      <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
      r_wstrb   <= w_wstrb_n;
      r_we      <= w_we_n;
      r_awvalid <= w_awvalid_n;
      r_wvalid  <= w_wvalid_n;
      r_bready  <= w_bready_n;
      r_arvalid <= w_arvalid_n;
      r_rready  <= w_rready_n;
      r_ack     <= w_ack_n;
      r_err     <= w_err_n;
      r_rdata   <= w_rdata_n;
      r_cnt     <= w_cnt_n;
    end
  end

  // next state, channel bookkeeping, termination and timeout
  always_comb begin
    w_state_n   = r_state;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_wstrb_n   = r_wstrb;
    w_we_n      = r_we;
    w_awvalid_n = r_awvalid;
    w_wvalid_n  = r_wvalid;
    w_bready_n  = r_bready;
    w_arvalid_n = r_arvalid;
    w_rready_n  = r_rready;
    w_ack_n     = 1'b0;
    w_err_n     = 1'b0;
    w_rdata_n   = r_rdata;
    w_cnt_n     = r_cnt;

    // outside IDLE each AXI channel runs the same way whether the request is live or draining
    if (r_state != IDLE) begin
      if (w_aw_hs) w_awvalid_n = 1'b0;
      if (w_w_hs)  w_wvalid_n  = 1'b0;
      if (w_ar_hs) w_arvalid_n = 1'b0;
      if (r_we) begin
        if (w_b_hs)                      w_bready_n = 1'b0;
        else if (w_aw_done && w_w_done)  w_bready_n = 1'b1;
      end else begin
        if (w_r_hs)                      w_rready_n = 1'b0;
        else if (w_ar_done)              w_rready_n = 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        // the cycle carrying ack/err still shows the old strobe; only the cycle after is a new request
        if (wb_cyc_i && wb_stb_i && !r_ack && !r_err) begin
          w_addr_n  = wb_adr_i;
          w_wdata_n = wb_dat_i;
          w_wstrb_n = wb_sel_i;
          w_we_n    = wb_we_i;
          if (wb_we_i) begin
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
            w_state_n   = WR;
          end else begin
            w_arvalid_n = 1'b1;
            w_state_n   = RD_ADDR;
          end
        end
      end
      WR, WR_RESP, RD_ADDR, RD_DATA: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_resp_hs) begin
          w_state_n = IDLE;
          if (wb_cyc_i) begin
            w_ack_n = ~w_resp_err;
            w_err_n = w_resp_err;
            if (w_r_hs) w_rdata_n = m_axi_rdata;
          end
        end else if (!wb_cyc_i) begin
          w_state_n = DRAIN;
        end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_n == TO_VAL)) begin
          w_err_n   = 1'b1;
          w_state_n = DRAIN;
        end else if (r_state == WR && w_aw_done && w_w_done) begin
          w_state_n = WR_RESP;
        end else if (r_state == RD_ADDR && w_ar_done) begin
          w_state_n = RD_DATA;
        end
      end
      DRAIN: begin
        if (w_resp_hs) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign wb_dat_o      = r_rdata;
  assign wb_ack_o      = r_ack;
  assign wb_err_o      = r_err;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
endmodule

// File: tb/tb_wb2axi4lite_bridge.sv
// tb/tb_wb2axi4lite_bridge.sv - self-checking bench for wb2axi4lite_bridge
module tb_wb2axi4lite_bridge;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  wb2axi4lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int pass_cnt = 0;
  int chk_cnt = 0;
  int ack_cnt = 0;
  int err_cnt = 0;

  // slave behaviour knobs
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit         ar_hang = 1'b0;

  // what the slave saw, in handshake order
  logic [31:0] aw_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [31:0] ar_q[$];
  int          b_done = 0;
  int          r_done = 0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_word(a);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    rmem[a] = (ref_read(a) & ~m) | (d & m);
  endtask

  always @(negedge clk) begin
    if (wb_ack_o) ack_cnt++;
    if (wb_err_o) err_cnt++;
  end

  initial begin
    m_axi_awready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_axi_awvalid) begin
        logic [31:0] a;
        repeat (aw_dly) @(negedge clk);
        a = m_axi_awaddr;
        m_axi_awready = 1'b1;
        @(posedge clk);
        #1 m_axi_awready = 1'b0;
        aw_q.push_back(a);
      end
    end
  end

  initial begin
    m_axi_wready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_axi_wvalid) begin
        logic [31:0] d;
        logic [3:0]  s;
        repeat (w_dly) @(negedge clk);
        d = m_axi_wdata;
        s = m_axi_wstrb;
        m_axi_wready = 1'b1;
        @(posedge clk);
        #1 m_axi_wready = 1'b0;
        wd_q.push_back(d);
        ws_q.push_back(s);
      end
    end
  end

  initial begin
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (aw_q.size() > b_done && wd_q.size() > b_done) begin
        logic [31:0] a, w;
        a = aw_q[b_done];
        w = smem.exists(a) ? smem[a] : init_word(a);
        for (int i = 0; i < 4; i++)
          if (ws_q[b_done][i]) w[i*8 +: 8] = wd_q[b_done][i*8 +: 8];
        smem[a] = w;
        repeat (b_dly) @(negedge clk);
        m_axi_bresp  = bresp_cfg;
        m_axi_bvalid = 1'b1;
        for (int k = 0; k < 200 && !m_axi_bready; k++) @(negedge clk);
        @(posedge clk);
        #1 m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00;
        b_done++;
      end
    end
  end

  initial begin
    m_axi_arready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_axi_arvalid) begin
        logic [31:0] a;
        for (int k = 0; k < 1000 && ar_hang; k++) @(negedge clk);
        repeat (ar_dly) @(negedge clk);
        a = m_axi_araddr;
        m_axi_arready = 1'b1;
        @(posedge clk);
        #1 m_axi_arready = 1'b0;
        ar_q.push_back(a);
      end
    end
  end

  initial begin
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = '0;
    m_axi_rresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (ar_q.size() > r_done) begin
        logic [31:0] a;
        a = ar_q[r_done];
        repeat (r_dly) @(negedge clk);
        m_axi_rdata  = smem.exists(a) ? smem[a] : init_word(a);
        m_axi_rresp  = rresp_cfg;
        m_axi_rvalid = 1'b1;
        for (int k = 0; k < 200 && !m_axi_rready; k++) @(negedge clk);
        @(posedge clk);
        #1 m_axi_rvalid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        r_done++;
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output int lat, output bit got_ack, output bit got_err,
                         output bit held);
    @(negedge clk);
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    while (lat < 60 && !got_ack && !got_err) begin
      @(negedge clk);
      lat++;
      got_ack = wb_ack_o;
      got_err = wb_err_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    held = wb_ack_o | wb_err_o;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({wb_dat_o, wb_ack_o, wb_err_o, m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
         m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready} !== '0)
      $display("FAIL reset_outputs got nonzero exp all zero (dat=%h ack=%b err=%b)", wb_dat_o, wb_ack_o, wb_err_o);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, wb_ack_o, wb_err_o} !== 5'b0)
      $display("FAIL idle_after_reset got activity exp none");
    else pass_cnt++;
  endtask

  task automatic test_write_basic();
    int lat; bit ga, ge, hd;
    aw_dly = 0; w_dly = 0; b_dly = 0; bresp_cfg = 2'b00;
    wb_xfer(32'h1000, 32'hDEADBEEF, 4'hF, 1'b1, lat, ga, ge, hd);
    ref_write(32'h1000, 32'hDEADBEEF, 4'hF);
    chk_cnt++; if (lat !== 3) $display("FAIL wr_latency got %0d exp 3", lat); else pass_cnt++;
    chk_cnt++; if ({ga, ge} !== 2'b10) $display("FAIL wr_ack_err got %b exp 10", {ga, ge}); else pass_cnt++;
    chk_cnt++; if (hd !== 1'b0) $display("FAIL wr_pulse_width got %b exp 0", hd); else pass_cnt++;
    chk_cnt++; if (aw_q[$] !== 32'h1000) $display("FAIL wr_awaddr got %h exp 00001000", aw_q[$]); else pass_cnt++;
    chk_cnt++; if (wd_q[$] !== 32'hDEADBEEF) $display("FAIL wr_wdata got %h exp deadbeef", wd_q[$]); else pass_cnt++;
    chk_cnt++; if (ws_q[$] !== 4'hF) $display("FAIL wr_wstrb got %h exp f", ws_q[$]); else pass_cnt++;
  endtask

  task automatic test_read_wait();
    int lat, rr_cyc, ovl; bit ga, ge, hd;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    wb_xfer(32'h2004, 32'hCAFEF00D, 4'hF, 1'b1, lat, ga, ge, hd);
    ref_write(32'h2004, 32'hCAFEF00D, 4'hF);
    chk_cnt++; if (ga !== 1'b1) $display("FAIL rd_preload_ack got %b exp 1", ga); else pass_cnt++;
    r_dly = 5; rr_cyc = 0; ovl = 0;
    fork
      wb_xfer(32'h2004, 32'h0, 4'hF, 1'b0, lat, ga, ge, hd);
      begin
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
          @(negedge clk);
          if (m_axi_rready) rr_cyc++;
          if (m_axi_rready && m_axi_arvalid) ovl++;
        end
      end
    join
    r_dly = 0;
    chk_cnt++; if (lat !== 8) $display("FAIL rd_latency got %0d exp 8", lat); else pass_cnt++;
    chk_cnt++; if ({ga, ge, hd} !== 3'b100) $display("FAIL rd_ack_err_held got %b exp 100", {ga, ge, hd}); else pass_cnt++;
    chk_cnt++; if (wb_dat_o !== ref_read(32'h2004)) $display("FAIL rd_data got %h exp %h", wb_dat_o, ref_read(32'h2004)); else pass_cnt++;
    chk_cnt++; if (rr_cyc !== 6 || ovl !== 0) $display("FAIL rd_rready_window got %0d/%0d exp 6/0", rr_cyc, ovl); else pass_cnt++;
  endtask

  task automatic test_write_split();
    int lat, a0; bit ga, ge, hd, split_ok;
    aw_dly = 0; w_dly = 4; b_dly = 0; bresp_cfg = 2'b00;
    a0 = ack_cnt; split_ok = 1'b0;
    fork
      wb_xfer(32'h1008, 32'h1234_5678, 4'h3, 1'b1, lat, ga, ge, hd);
      begin
        @(negedge clk);
        repeat (2) @(negedge clk);
        split_ok = (m_axi_awvalid === 1'b0) && (m_axi_wvalid === 1'b1);
      end
    join
    w_dly = 0;
    ref_write(32'h1008, 32'h1234_5678, 4'h3);
    chk_cnt++; if (lat !== 7) $display("FAIL split_latency got %0d exp 7", lat); else pass_cnt++;
    chk_cnt++; if (split_ok !== 1'b1) $display("FAIL split_valids got %b exp 1", split_ok); else pass_cnt++;
    chk_cnt++; if (ws_q[$] !== 4'h3) $display("FAIL split_wstrb got %h exp 3", ws_q[$]); else pass_cnt++;
    chk_cnt++; if (ack_cnt - a0 !== 1) $display("FAIL split_ack_count got %0d exp 1", ack_cnt - a0); else pass_cnt++;
  endtask

  task automatic test_read_slverr();
    int lat, a0; bit ga, ge, hd;
    ar_dly = 0; r_dly = 1; rresp_cfg = 2'b10; a0 = ack_cnt;
    wb_xfer(32'h1008, 32'h0, 4'hF, 1'b0, lat, ga, ge, hd);
    rresp_cfg = 2'b00; r_dly = 0;
    chk_cnt++; if ({ga, ge, hd} !== 3'b010) $display("FAIL slverr_ack_err_held got %b exp 010", {ga, ge, hd}); else pass_cnt++;
    chk_cnt++; if (ack_cnt - a0 !== 0) $display("FAIL slverr_no_ack got %0d exp 0", ack_cnt - a0); else pass_cnt++;
    chk_cnt++; if (wb_dat_o !== ref_read(32'h1008)) $display("FAIL slverr_data got %h exp %h", wb_dat_o, ref_read(32'h1008)); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int t_ar, t_err, a0, e0, r0, lat; bit ga, ge, hd; logic [31:0] dat0;
    ar_dly = 0; r_dly = 2; ar_hang = 1'b1;
    a0 = ack_cnt; e0 = err_cnt; r0 = r_done; dat0 = wb_dat_o; t_ar = -1; t_err = -1;
    @(negedge clk);
    wb_adr_i = 32'h4000; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_axi_arvalid && t_ar < 0) t_ar = i;
      if (wb_err_o) begin t_err = i; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk_cnt++; if (t_err - t_ar !== TO) $display("FAIL timeout_delay got %0d exp %0d", t_err - t_ar, TO); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (m_axi_arvalid !== 1'b1) $display("FAIL drain_arvalid got %b exp 1", m_axi_arvalid); else pass_cnt++;
    ar_hang = 1'b0;
    for (int k = 0; k < 60 && r_done == r0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    r_dly = 0;
    chk_cnt++; if (r_done !== r0 + 1) $display("FAIL drain_read_done got %0d exp %0d", r_done, r0 + 1); else pass_cnt++;
    chk_cnt++; if (ack_cnt - a0 !== 0 || err_cnt - e0 !== 1) $display("FAIL timeout_pulses got ack %0d err %0d exp 0 1", ack_cnt - a0, err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (wb_dat_o !== dat0) $display("FAIL drain_dat_hold got %h exp %h", wb_dat_o, dat0); else pass_cnt++;
    wb_xfer(32'h2004, 32'h0, 4'hF, 1'b0, lat, ga, ge, hd);
    chk_cnt++; if ({ga, wb_dat_o} !== {1'b1, ref_read(32'h2004)}) $display("FAIL post_drain_read got %b/%h exp 1/%h", ga, wb_dat_o, ref_read(32'h2004)); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int a0, e0, n0, r0; logic [31:0] dat0;
    aw_dly = 0; w_dly = 0; b_dly = 1; bresp_cfg = 2'b00;
    a0 = ack_cnt; n0 = aw_q.size();
    @(negedge clk);
    wb_adr_i = 32'h1100; wb_dat_i = 32'hA1A1_A1A1; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (wb_ack_o) break; end
    wb_adr_i = 32'h1104; wb_dat_i = 32'hB2B2_B2B2;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (wb_ack_o) break; end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (4) @(negedge clk);
    b_dly = 0;
    ref_write(32'h1100, 32'hA1A1_A1A1, 4'hF);
    ref_write(32'h1104, 32'hB2B2_B2B2, 4'hF);
    chk_cnt++; if (ack_cnt - a0 !== 2) $display("FAIL b2b_ack_count got %0d exp 2", ack_cnt - a0); else pass_cnt++;
    chk_cnt++; if (aw_q.size() - n0 !== 2) $display("FAIL b2b_aw_count got %0d exp 2", aw_q.size() - n0); else pass_cnt++;
    chk_cnt++; if (aw_q.size() < n0 + 2 || aw_q[n0] !== 32'h1100 || aw_q[n0+1] !== 32'h1104 || wd_q[n0+1] !== 32'hB2B2_B2B2)
      $display("FAIL b2b_order got %h,%h exp 00001100,00001104", aw_q[n0], aw_q[n0+1]); else pass_cnt++;
    // read aborted while waiting on RDATA
    a0 = ack_cnt; e0 = err_cnt; r0 = r_done; dat0 = wb_dat_o; r_dly = 6;
    @(negedge clk);
    wb_adr_i = 32'h1100; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (3) @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk_cnt++; if (m_axi_rready !== 1'b1) $display("FAIL abort_rready_held got %b exp 1", m_axi_rready); else pass_cnt++;
    for (int k = 0; k < 60 && r_done == r0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    r_dly = 0;
    chk_cnt++; if (ack_cnt - a0 !== 0 || err_cnt - e0 !== 0) $display("FAIL abort_pulses got ack %0d err %0d exp 0 0", ack_cnt - a0, err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (r_done !== r0 + 1 || wb_dat_o !== dat0) $display("FAIL abort_drain got done %0d dat %h exp %0d %h", r_done, wb_dat_o, r0 + 1, dat0); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, exp_lat; bit ga, ge, hd;
    logic we; logic [31:0] adr, dat; logic [3:0] sel; logic [1:0] resp;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(0, 1));
      adr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      resp = 2'($urandom_range(0, 3));
      aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
      bresp_cfg = resp; rresp_cfg = resp;
      exp_lat = we ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      wb_xfer(adr, dat, sel, we, lat, ga, ge, hd);
      chk_cnt++; if (lat !== exp_lat) $display("FAIL rnd%0d_latency got %0d exp %0d", n, lat, exp_lat); else pass_cnt++;
      chk_cnt++; if ({ga, ge, hd} !== {~resp[1], resp[1], 1'b0}) $display("FAIL rnd%0d_term got %b exp %b", n, {ga, ge, hd}, {~resp[1], resp[1], 1'b0}); else pass_cnt++;
      if (we) begin
        chk_cnt++;
        if ({aw_q[$], wd_q[$], ws_q[$]} !== {adr, dat, sel})
          $display("FAIL rnd%0d_wr_chan got %h/%h/%h exp %h/%h/%h", n, aw_q[$], wd_q[$], ws_q[$], adr, dat, sel);
        else pass_cnt++;
        ref_write(adr, dat, sel);
      end else begin
        chk_cnt++; if (wb_dat_o !== ref_read(adr)) $display("FAIL rnd%0d_rd_data got %h exp %h", n, wb_dat_o, ref_read(adr)); else pass_cnt++;
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_split();
    test_read_slverr();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
